// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD arithmetic datapath.
package bcd_pkg;
   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bi, combinational; result wraps modulo 10 with borrow-out.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               bi,
   output logic [DIGIT_W-1:0] d,
   output logic               bo
);
   logic signed [4:0] t;
   logic signed [4:0] t_wrap;

   always_comb begin
      t      = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bi});
      t_wrap = t + 5'sd10;
      bo     = 1'b0;
      d      = t[3:0];
      if (t < 5'sd0) begin
         bo = 1'b1;
         d  = t_wrap[3:0];
      end
   end
endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor A - B - bin, LSD first; a negative raw result gets a
// second serial pass (0 - raw) so diff is always a magnitude, with neg carrying the sign.
module bcd_sub_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  bout,
   output logic                  err
);
   localparam int W     = DIGIT_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [W-1:0]     res_q, res_d, diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             neg_q, neg_d, bout_q, bout_d, err_q, err_d;

   logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
   logic               dig_bo;
   logic               bad_digit;
   logic [W-1:0]       res_shift;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[DIGIT_W*i +: DIGIT_W] > BCD_MAX || b[DIGIT_W*i +: DIGIT_W] > BCD_MAX)
            bad_digit = 1'b1;
      end
   end

   // The NEG pass reuses the digit subtractor as 0 - raw digit.
   always_comb begin
      dig_x = (state_q == NEG) ? '0 : a_q[DIGIT_W-1:0];
      dig_y = (state_q == NEG) ? res_q[DIGIT_W-1:0] : b_q[DIGIT_W-1:0];
   end

   bcd_digit_sub u_digit (
      .x  (dig_x),
      .y  (dig_y),
      .bi (brw_q),
      .d  (dig_d),
      .bo (dig_bo)
   );

   assign res_shift = (res_q >> DIGIT_W) | (W'(dig_d) << (W - DIGIT_W));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      neg_d   = neg_q;
      bout_d  = bout_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               res_d   = '0;
               cnt_d   = '0;
               neg_d   = 1'b0;
               bout_d  = 1'b0;
               err_d   = bad_digit;
               if (bad_digit) begin
                  diff_d  = '0;
                  state_d = DONE;
               end else begin
                  state_d = SUB;
               end
            end
         end
         SUB: begin
            a_d   = a_q >> DIGIT_W;
            b_d   = b_q >> DIGIT_W;
            res_d = res_shift;
            brw_d = dig_bo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d  = '0;
               bout_d = dig_bo;
               if (dig_bo) begin
                  neg_d   = 1'b1;
                  brw_d   = 1'b0;
                  state_d = NEG;
               end else begin
                  diff_d  = res_shift;
                  state_d = DONE;
               end
            end
         end
         NEG: begin
            res_d = res_shift;
            brw_d = dig_bo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               diff_d  = res_shift;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         neg_q   <= 1'b0;
         bout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         neg_q   <= neg_d;
         bout_q  <= bout_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign neg  = neg_q;
   assign bout = bout_q;
   assign err  = err_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial with DIGITS=4, checked against an integer-arithmetic model.
module tb_bcd_sub_serial;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst, start, bin;
   logic [15:0] a, b;
   logic        busy, done, neg, bout, err;
   logic [15:0] diff;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_prev = 16'h0;

   bcd_sub_serial #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .neg(neg), .bout(bout), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic model(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output logic [15:0] ed, output logic en, output logic eb,
                        output logic ee, output int el);
      int r;
      ee = 1'b0;
      for (int i = 0; i < D; i++)
         if (ia[4*i +: 4] > 4'd9 || ib[4*i +: 4] > 4'd9) ee = 1'b1;
      if (ee) begin
         ed = '0; en = 1'b0; eb = 1'b0; el = 1;
      end else begin
         r  = bcd2int(ia) - bcd2int(ib) - int'(ibin);
         en = (r < 0);
         eb = en;
         ed = int2bcd(en ? -r : r);
         el = en ? 2 * D + 1 : D + 1;
      end
   endtask

   // Starts one operation and returns what the DUT shows in its done cycle.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output int lat, output logic [15:0] od, output logic on,
                        output logic ob, output logic oe, output logic hold_bad);
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      hold_bad = 1'b0;
      while (!done && lat < 60) begin
         if (diff !== exp_prev) hold_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      od = diff; on = neg; ob = bout; oe = err;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, neg, bout, err, diff} !== 21'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b neg=%b bout=%b err=%b diff=%h want all 0",
                  busy, done, neg, bout, err, diff);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic run_and_check(input string name, input logic [15:0] ia,
                                input logic [15:0] ib, input logic ibin);
      logic [15:0] ed, od;
      logic en, eb, ee, on, ob, oe, hb;
      int el, lat;
      model(ia, ib, ibin, ed, en, eb, ee, el);
      do_op(ia, ib, ibin, lat, od, on, ob, oe, hb);
      checks++;
      if (lat != el || od !== ed || on !== en || ob !== eb || oe !== ee) begin
         errors++;
         $display("FAIL %s a=%h b=%h bin=%b: got lat=%0d diff=%h neg=%b bout=%b err=%b want lat=%0d diff=%h neg=%b bout=%b err=%b",
                  name, ia, ib, ibin, lat, od, on, ob, oe, el, ed, en, eb, ee);
      end
      checks++;
      if (hb !== 1'b0) begin
         errors++;
         $display("FAIL %s_diff_hold: diff changed before done, got flag=%b want 0", name, hb);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== ed) begin
         errors++;
         $display("FAIL %s_after_done: got done=%b busy=%b diff=%h want 0 0 %h", name, done, busy, diff, ed);
      end
      exp_prev = ed;
   endtask

   task automatic test_directed;
      run_and_check("pos_0042_0017", 16'h0042, 16'h0017, 1'b0);
      run_and_check("neg_0017_0042", 16'h0017, 16'h0042, 1'b0);
      run_and_check("ripple_1000_0001", 16'h1000, 16'h0001, 1'b0);
      run_and_check("zero_minus_bin", 16'h0000, 16'h0000, 1'b1);
      run_and_check("equal_zero", 16'h0555, 16'h0555, 1'b0);
   endtask

   task automatic test_err;
      run_and_check("err_00A0", 16'h00A0, 16'h0001, 1'b0);
      run_and_check("err_cleared", 16'h0300, 16'h0299, 1'b0);
   endtask

   task automatic test_busy_ignore;
      int dones = 0;
      logic [15:0] seen = '0;
      @(negedge clk);
      a = 16'h9999; b = 16'h0000; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002;
      repeat (3) @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) begin dones++; seen = diff; end
      end
      checks++;
      if (dones != 1 || seen !== 16'h9999) begin
         errors++;
         $display("FAIL busy_ignore: got dones=%0d diff=%h want 1 9999", dones, seen);
      end
      exp_prev = 16'h9999;
   endtask

   task automatic test_back_to_back;
      int n = 0;
      @(negedge clk);
      a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_reaccept: got busy=%b want 1", busy);
      end
      n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (done !== 1'b1 || diff !== 16'h0025 || neg !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got done=%b diff=%h neg=%b want 1 0025 0", done, diff, neg);
      end
      @(posedge clk); #1;
      exp_prev = 16'h0025;
   endtask

   task automatic test_reset_mid;
      int dones = 0;
      @(negedge clk);
      a = 16'h0017; b = 16'h0042; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (D + 1) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, neg, bout, err, diff} !== 21'h0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b neg=%b bout=%b err=%b diff=%h want all 0",
                  busy, done, neg, bout, err, diff);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got dones=%0d want 0", dones);
      end
      exp_prev = 16'h0;
      run_and_check("after_reset", 16'h0042, 16'h0017, 1'b0);
   endtask

   task automatic test_random;
      logic [15:0] ra, rb;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < D; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         run_and_check("random", ra, rb, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_err;
      test_busy_ignore;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
